cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 146 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Purpose: bridges one cache-line request to a BEATS-long memory burst (read assemble / write split).
// Latency: burst request from the cycle after acceptance; resp_o one cycle after the last beat.
// Backpressure: memory paces beats with resp_i (gaps hold state); cache holds its request until resp_o.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = s_line / s_burst;
    localparam int CW    = $clog2(BEATS);
    localparam int OFFW  = $clog2(s_line / 8);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
    // Clears the byte-offset-within-line bits of the address.
    localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << OFFW) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       cnt;
    logic [31:0]         addr_q;
    logic [s_line-1:0]   wline_q;
    logic [s_line-1:0]   rline_q;
    logic                accept_wr;
    logic                accept_rd;
    logic                beat;
    logic [s_burst-1:0]  wr_slice;

    assign line_o = rline_q;

    // State register; reset aborts any burst in flight without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Select the write slice addressed by the beat counter.
    always_comb begin
        wr_slice = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (int'(cnt) == i) begin
                wr_slice = wline_q[i*s_burst +: s_burst];
            end
        end
    end

    // Next-state and output decode; outputs depend only on state so reset zeroes them at once.
    always_comb begin
        next_state = state;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        address_o  = '0;
        burst_o    = '0;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                // Write wins when both requests are raised together.
                if (write_i) begin
                    accept_wr  = 1'b1;
                    next_state = WR_BURST;
                end else if (read_i) begin
                    accept_rd  = 1'b1;
                    next_state = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o    = 1'b1;
                address_o = addr_q & ALIGN_MASK;
                if (resp_i) begin
                    beat = 1'b1;
                    if (cnt == LAST_BEAT) next_state = RD_DONE;
                end
            end
            WR_BURST: begin
                write_o   = 1'b1;
                address_o = addr_q & ALIGN_MASK;
                burst_o   = wr_slice;
                if (resp_i) begin
                    beat = 1'b1;
                    if (cnt == LAST_BEAT) next_state = WR_DONE;
                end
            end
            RD_DONE, WR_DONE: begin
                resp_o     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch request, step the beat counter, assemble read beats into line_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            if (accept_wr) begin
                addr_q  <= address_i;
                wline_q <= line_i;
                cnt     <= '0;
            end else if (accept_rd) begin
                addr_q <= address_i;
                cnt    <= '0;
            end else if (beat) begin
                cnt <= cnt + CW'(1);
            end
            if (beat && state == RD_BURST) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (int'(cnt) == i) begin
                        rline_q[i*s_burst +: s_burst] <= burst_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Purpose: directed self-checking bench for cacheline_adaptor at default 256/64 geometry.
// Latency: checks exact cycle of burst request, last beat and single-cycle resp_o.
// Backpressure: exercises resp_i gaps on reads and writes, reset mid-burst, back-to-back requests.
module tb_cacheline_adaptor;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic         clk;
    logic         rst_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int nvec;
    int nerr;

    // Beat data driven on reads, and expected write slices, set per test.
    logic [63:0]  bd [4];
    logic [63:0]  es [4];

    cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise read, drive resp_i pattern (bit c = cycle c of the burst); ends in the DONE cycle.
    task automatic read_xfer(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [15:0] pat, input int plen, input logic [255:0] exp_line);
        int k;
        k = 0;
        read_i    = 1'b1;
        address_i = addr;
        tick;
        chk({tag, ":read_o"}, read_o, 1);
        chk({tag, ":address_o"}, address_o, exp_addr);
        chk({tag, ":write_o"}, write_o, 0);
        for (int c = 0; c < plen; c++) begin
            resp_i  = pat[c];
            burst_i = pat[c] ? bd[k] : JUNK;
            if (pat[c]) k++;
            chk({tag, ":read_o_hold"}, read_o, 1);
            chk({tag, ":resp_o_early"}, resp_o, 0);
            tick;
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk({tag, ":resp_o"}, resp_o, 1);
        chk({tag, ":read_o_drop"}, read_o, 0);
        chk({tag, ":address_o_done"}, address_o, 0);
        chk({tag, ":line_o"}, line_o, exp_line);
    endtask

    // Raise write (optionally read too), check slices against es[]; ends in the DONE cycle.
    task automatic write_xfer(input string tag, input logic [31:0] addr, input logic [31:0] exp_addr,
                              input logic [255:0] line, input logic [15:0] pat, input int plen,
                              input logic rd_too);
        int k;
        k = 0;
        write_i   = 1'b1;
        read_i    = rd_too;
        address_i = addr;
        line_i    = line;
        tick;
        line_i = '0;
        chk({tag, ":write_o"}, write_o, 1);
        chk({tag, ":address_o"}, address_o, exp_addr);
        for (int c = 0; c < plen; c++) begin
            resp_i = pat[c];
            chk({tag, ":burst_o"}, burst_o, es[k]);
            chk({tag, ":read_o_low"}, read_o, 0);
            chk({tag, ":write_o_hold"}, write_o, 1);
            if (pat[c]) k++;
            tick;
        end
        resp_i = 1'b0;
        chk({tag, ":resp_o"}, resp_o, 1);
        chk({tag, ":write_o_drop"}, write_o, 0);
        chk({tag, ":read_o_done"}, read_o, 0);
        chk({tag, ":burst_o_done"}, burst_o, 0);
    endtask

    // In the DONE cycle: drop requests, poke resp_i with junk (must be ignored), land in IDLE.
    task automatic drop_req(input string tag, input logic [255:0] exp_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b1;
        burst_i = JUNK;
        tick;
        resp_i  = 1'b0;
        burst_i = '0;
        chk({tag, ":resp_o_one"}, resp_o, 0);
        chk({tag, ":read_o_idle"}, read_o, 0);
        chk({tag, ":write_o_idle"}, write_o, 0);
        chk({tag, ":line_o_kept"}, line_o, exp_line);
    endtask

    localparam logic [255:0] LINE1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    localparam logic [255:0] WL1   = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    localparam logic [255:0] LINE2 = 256'hD4D4D4D4D4D4D4D4_C3C3C3C3C3C3C3C3_B2B2B2B2B2B2B2B2_A1A1A1A1A1A1A1A1;
    localparam logic [255:0] WL2   = 256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD;
    localparam logic [255:0] LINE3 = 256'h0000000000000008_0000000000000007_0000000000000006_0000000000000005;
    localparam logic [255:0] LINE4 = 256'hF0F0F0F0F0F0F0F0_E0E0E0E0E0E0E0E0_D0D0D0D0D0D0D0D0_C0C0C0C0C0C0C0C0;

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        // Reset state.
        tick;
        tick;
        chk("rst:read_o", read_o, 0);
        chk("rst:write_o", write_o, 0);
        chk("rst:resp_o", resp_o, 0);
        chk("rst:address_o", address_o, 0);
        chk("rst:burst_o", burst_o, 0);
        chk("rst:line_o", line_o, 0);
        rst_n = 1'b1;
        tick;

        // Read, four consecutive beats.
        bd[0] = 64'h1111111111111111; bd[1] = 64'h2222222222222222;
        bd[2] = 64'h3333333333333333; bd[3] = 64'h4444444444444444;
        read_xfer("rd1", 32'h0000_1234, 32'h0000_1220, 16'b1111, 4, LINE1);
        drop_req("rd1", LINE1);

        // Write, resp_i held high; line_o must be untouched by the write.
        es[0] = 64'h8899AABBCCDDEEFF; es[1] = 64'h0011223344556677;
        es[2] = 64'hFEDCBA9876543210; es[3] = 64'h0123456789ABCDEF;
        write_xfer("wr1", 32'h0000_2047, 32'h0000_2040, WL1, 16'b1111, 4, 1'b0);
        drop_req("wr1", LINE1);

        // Read with gapped beats: resp_i = 1,0,0,1,1,0,1.
        bd[0] = 64'hA1A1A1A1A1A1A1A1; bd[1] = 64'hB2B2B2B2B2B2B2B2;
        bd[2] = 64'hC3C3C3C3C3C3C3C3; bd[3] = 64'hD4D4D4D4D4D4D4D4;
        read_xfer("rd_gap", 32'h0000_ABCD, 32'h0000_ABC0, 16'b1011001, 7, LINE2);
        drop_req("rd_gap", LINE2);

        // Read and write raised together: write wins, read_o never rises; gap on beat 1.
        es[0] = 64'hDDDDDDDDDDDDDDDD; es[1] = 64'hCCCCCCCCCCCCCCCC;
        es[2] = 64'hBBBBBBBBBBBBBBBB; es[3] = 64'hAAAAAAAAAAAAAAAA;
        write_xfer("wr_rd", 32'h8000_003F, 32'h8000_0020, WL2, 16'b11101, 5, 1'b1);
        drop_req("wr_rd", LINE2);

        // Reset pulsed after beat 2 of a read.
        bd[0] = 64'h0000000000000001; bd[1] = 64'h0000000000000002;
        bd[2] = 64'h0000000000000003; bd[3] = 64'h0000000000000004;
        read_i    = 1'b1;
        address_i = 32'h0000_0040;
        tick;
        for (int c = 0; c < 3; c++) begin
            resp_i  = 1'b1;
            burst_i = bd[c];
            tick;
        end
        chk("rst_mid:read_o_before", read_o, 1);
        rst_n   = 1'b0;
        read_i  = 1'b0;
        resp_i  = 1'b0;
        burst_i = '0;
        #1;
        chk("rst_mid:read_o", read_o, 0);
        chk("rst_mid:address_o", address_o, 0);
        chk("rst_mid:line_o", line_o, 0);
        chk("rst_mid:resp_o", resp_o, 0);
        chk("rst_mid:write_o", write_o, 0);
        chk("rst_mid:burst_o", burst_o, 0);
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rst_mid:no_resp", resp_o, 0);
        end
        bd[0] = 64'h0000000000000005; bd[1] = 64'h0000000000000006;
        bd[2] = 64'h0000000000000007; bd[3] = 64'h0000000000000008;
        read_xfer("rd_post", 32'h0000_0040, 32'h0000_0040, 16'b1111, 4, LINE3);
        drop_req("rd_post", LINE3);

        // Back-to-back write then read: each accepted in the IDLE cycle after the prior DONE.
        es[0] = 64'h8899AABBCCDDEEFF; es[1] = 64'h0011223344556677;
        es[2] = 64'hFEDCBA9876543210; es[3] = 64'h0123456789ABCDEF;
        write_xfer("b2b_wr", 32'h0000_3000, 32'h0000_3000, WL1, 16'b1111, 4, 1'b0);
        drop_req("b2b_wr", LINE3);
        bd[0] = 64'hC0C0C0C0C0C0C0C0; bd[1] = 64'hD0D0D0D0D0D0D0D0;
        bd[2] = 64'hE0E0E0E0E0E0E0E0; bd[3] = 64'hF0F0F0F0F0F0F0F0;
        read_xfer("b2b_rd", 32'h0000_30FF, 32'h0000_30E0, 16'b1111, 4, LINE4);
        drop_req("b2b_rd", LINE4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Run-away guard.
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, %0d vectors applied", nvec);
        $fatal(1, "watchdog expired");
    end

endmodule
